// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the PC generator: FSM states, pending-slot kinds, defaults.
package pc_gen_pkg;

  typedef enum logic [1:0] {BOOT, RUN, HELD} pc_state_e;

  typedef enum logic [1:0] {NONE, REDIR, TRAP} pend_kind_e;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/pc_redirect_latch.sv
// Single pending slot for redirects/traps seen while fetch is held; a trap always wins the slot.
// Captures on the edge where capture=1, visible next cycle; clear has priority over capture.
module pc_redirect_latch import pc_gen_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            capture,
  input  logic            clear,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output pend_kind_e      kind,
  output logic [XLEN-1:0] target
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      kind   <= NONE;
      target <= '0;
    end else if (clear) begin
      kind   <= NONE;
      target <= '0;
    end else if (capture) begin
      if (trap_valid) begin
        kind   <= TRAP;
        target <= trap_target;
      end else if (redirect_valid && (kind != TRAP)) begin
        kind   <= REDIR;
        target <= redirect_target;
      end
    end
  end

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch PC generator: boot delay, trap > redirect > pc+4, one-cycle redirect latency, hold with pending slot.
// PC_MISALIGN_TRAP_EN: misaligned targets go to TRAP_VECTOR with misalign_o/bad_addr_o; otherwise bits [1:0] are cleared.
module pc_gen_unit import pc_gen_pkg::*; #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter int unsigned     BOOT_DELAY   = 2,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            busy_i,
  input  logic            stall_i,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_target_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pc_valid_o,
  output logic            redirect_pending_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] bad_addr_o
);

  pc_state_e       state, state_nxt;
  logic [3:0]      boot_cnt, boot_cnt_nxt;
  logic            hold;
  logic            upd, tgt_sel, capture, clear;
  logic [XLEN-1:0] tgt, pc_seq, pc_next;
  pend_kind_e      pend_kind;
  logic [XLEN-1:0] pend_target;

  assign hold   = busy_i | stall_i;
  assign pc_seq = pc_o + XLEN'(INSTR_BYTES);

  // Requests arriving on the edge that enters HELD are captured too, so none is lost.
  pc_redirect_latch #(.XLEN(XLEN)) u_latch (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .capture         (capture),
    .clear           (clear),
    .trap_valid      (trap_valid_i),
    .trap_target     (trap_target_i),
    .redirect_valid  (redirect_valid_i),
    .redirect_target (redirect_target_i),
    .kind            (pend_kind),
    .target          (pend_target)
  );

  always_comb begin
    state_nxt    = state;
    boot_cnt_nxt = boot_cnt;
    upd          = 1'b0;
    tgt_sel      = 1'b0;
    tgt          = '0;
    capture      = 1'b0;
    clear        = 1'b0;
    case (state)
      BOOT: begin
        if (({1'b0, boot_cnt} + 5'd1) >= 5'(BOOT_DELAY)) state_nxt = RUN;
        else boot_cnt_nxt = boot_cnt + 4'd1;
      end
      RUN: begin
        if (hold) begin
          state_nxt = HELD;
          capture   = 1'b1;
        end else begin
          upd = 1'b1;
          if (trap_valid_i) begin
            tgt_sel = 1'b1;
            tgt     = trap_target_i;
          end else if (redirect_valid_i) begin
            tgt_sel = 1'b1;
            tgt     = redirect_target_i;
          end
        end
      end
      HELD: begin
        if (hold) begin
          capture = 1'b1;
        end else begin
          upd       = 1'b1;
          clear     = 1'b1;
          state_nxt = RUN;
          if (trap_valid_i) begin
            tgt_sel = 1'b1;
            tgt     = trap_target_i;
          end else if (pend_kind == TRAP) begin
            tgt_sel = 1'b1;
            tgt     = pend_target;
          end else if (redirect_valid_i) begin
            tgt_sel = 1'b1;
            tgt     = redirect_target_i;
          end else if (pend_kind == REDIR) begin
            tgt_sel = 1'b1;
            tgt     = pend_target;
          end
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic mis;
  assign mis     = tgt_sel && (tgt[1:0] != 2'b00);
  assign pc_next = mis ? TRAP_VECTOR : (tgt_sel ? tgt : pc_seq);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      misalign_o <= 1'b0;
      bad_addr_o <= '0;
    end else begin
      misalign_o <= upd & mis;
      if (upd && mis) bad_addr_o <= tgt;
    end
  end
`else
  assign pc_next    = tgt_sel ? (tgt & ~XLEN'(INSTR_BYTES - 1)) : pc_seq;
  assign misalign_o = 1'b0;
  assign bad_addr_o = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= BOOT;
      boot_cnt <= '0;
      pc_o     <= RESET_VECTOR;
    end else begin
      state    <= state_nxt;
      boot_cnt <= boot_cnt_nxt;
      if (upd) pc_o <= pc_next;
    end
  end

  assign pc_valid_o         = (state != BOOT);
  assign redirect_pending_o = (pend_kind != NONE);

endmodule

// File: tb/tb_pc_gen_unit.sv
// Bench for pc_gen_unit: directed scenarios then random traffic against a queue-based reference model.
module tb_pc_gen_unit;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;
  localparam int          BD = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni, busy_i, stall_i, trap_valid_i, redirect_valid_i;
  logic [31:0] trap_target_i, redirect_target_i;
  logic [31:0] pc_o, bad_addr_o;
  logic        pc_valid_o, redirect_pending_o, misalign_o;

  int checks = 0;
  int errors = 0;

  pc_gen_unit #(.XLEN(32), .RESET_VECTOR(RV), .BOOT_DELAY(BD), .TRAP_VECTOR(TV)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .busy_i(busy_i), .stall_i(stall_i),
    .trap_valid_i(trap_valid_i), .trap_target_i(trap_target_i),
    .redirect_valid_i(redirect_valid_i), .redirect_target_i(redirect_target_i),
    .pc_o(pc_o), .pc_valid_o(pc_valid_o), .redirect_pending_o(redirect_pending_o),
    .misalign_o(misalign_o), .bad_addr_o(bad_addr_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: boot edge count, PC value and a queue holding at most one pending request.
  typedef struct { bit is_trap; logic [31:0] addr; } pend_t;
  pend_t       m_pend[$];
  bit          m_run;
  int          m_boot_edges;
  logic [31:0] m_pc, m_bad;
  bit          m_mis;

  function automatic void m_reset();
    m_pend.delete();
    m_run = 0; m_boot_edges = 0; m_pc = RV; m_bad = 0; m_mis = 0;
  endfunction

  function automatic void m_load(logic [31:0] a);
`ifdef PC_MISALIGN_TRAP_EN
    if (a % 4 != 0) begin m_pc = TV; m_mis = 1; m_bad = a; end
    else m_pc = a;
`else
    m_pc = a - (a % 4);
`endif
  endfunction

  function automatic void m_step(bit b, bit s, bit tv, logic [31:0] tt, bit rv, logic [31:0] rt);
    bit pend_trap;
    m_mis = 0;
    if (!m_run) begin
      m_boot_edges++;
      if (m_boot_edges >= ((BD > 0) ? BD : 1)) m_run = 1;
      return;
    end
    pend_trap = (m_pend.size() != 0) && m_pend[0].is_trap;
    if (b || s) begin
      if (tv) begin m_pend.delete(); m_pend.push_back('{1'b1, tt}); end
      else if (rv && !pend_trap) begin m_pend.delete(); m_pend.push_back('{1'b0, rt}); end
    end else begin
      if (tv) m_load(tt);
      else if (pend_trap) m_load(m_pend[0].addr);
      else if (rv) m_load(rt);
      else if (m_pend.size() != 0) m_load(m_pend[0].addr);
      else m_pc = m_pc + 32'd4;
      m_pend.delete();
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},    pc_o, m_pc);
    check({tag, ".valid"}, {31'd0, pc_valid_o}, {31'd0, m_run});
    check({tag, ".pend"},  {31'd0, redirect_pending_o}, {31'd0, m_pend.size() != 0});
    check({tag, ".mis"},   {31'd0, misalign_o}, {31'd0, m_mis});
`ifdef PC_MISALIGN_TRAP_EN
    check({tag, ".bad"},   bad_addr_o, m_bad);
`else
    check({tag, ".bad"},   bad_addr_o, 32'd0);
`endif
  endtask

  task automatic tick(input bit b, input bit s, input bit tv, input logic [31:0] tt,
                      input bit rv, input logic [31:0] rt, input string tag);
    busy_i = b; stall_i = s; trap_valid_i = tv; trap_target_i = tt;
    redirect_valid_i = rv; redirect_target_i = rt;
    @(posedge clk_i);
    m_step(b, s, tv, tt, rv, rt);
    #1;
    check_all(tag);
  endtask

  task automatic assert_reset(input string tag);
    rst_ni = 1'b0;
    #1;
    m_reset();
    check_all(tag);
  endtask

  task automatic release_reset(input string tag);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    check_all(tag);
  endtask

  initial begin
    logic [31:0] a1, a2;
    rst_ni = 1'b1; busy_i = 0; stall_i = 0; trap_valid_i = 0; redirect_valid_i = 0;
    trap_target_i = 0; redirect_target_i = 0;
    #1;
    assert_reset("rst");
    check("rst_pc_const", pc_o, RV);
    release_reset("rel");

    // Boot: redirect during BOOT is dropped, first valid PC is the reset vector.
    tick(0, 0, 0, 0, 1, 32'h500, "boot1");
    check("boot1_valid0", {31'd0, pc_valid_o}, 32'd0);
    tick(0, 0, 0, 0, 0, 0, "boot2");
    check("boot2_pc0", pc_o, 32'h0);
    tick(0, 0, 0, 0, 0, 0, "seq4");
    check("seq_pc4", pc_o, 32'h4);
    tick(0, 0, 0, 0, 0, 0, "seq8");
    check("seq_pc8", pc_o, 32'h8);

    tick(0, 0, 0, 0, 1, 32'h200, "redir");
    check("redir_pc", pc_o, 32'h200);
    tick(0, 0, 0, 0, 0, 0, "redir_next");
    check("redir_next_pc", pc_o, 32'h204);

    // Hold with redirect then trap pending; trap wins on release.
    tick(0, 1, 0, 0, 0, 0, "hold0");
    tick(0, 1, 0, 0, 1, 32'h300, "hold_redir");
    check("hold_pend", {31'd0, redirect_pending_o}, 32'd1);
    check("hold_pc_frozen", pc_o, 32'h204);
    tick(0, 1, 1, 32'h100, 0, 0, "hold_trap");
    tick(0, 0, 0, 0, 0, 0, "release");
    check("release_pc", pc_o, 32'h100);
    check("release_pend", {31'd0, redirect_pending_o}, 32'd0);

    tick(0, 0, 0, 0, 1, 32'hFFFF_FFFC, "wrap_a");
    tick(0, 0, 0, 0, 0, 0, "wrap_b");
    check("wrap_pc", pc_o, 32'h0);

    // Asynchronous reset while held with a pending redirect.
    tick(1, 0, 0, 0, 0, 0, "held2");
    tick(1, 0, 0, 0, 1, 32'h400, "held2_redir");
    assert_reset("midrst");
    check("midrst_pc", pc_o, RV);
    check("midrst_pend", {31'd0, redirect_pending_o}, 32'd0);
    release_reset("midrel");
    tick(0, 0, 0, 0, 0, 0, "reboot1");
    tick(0, 0, 0, 0, 0, 0, "reboot2");

    tick(0, 0, 0, 0, 1, 32'h202, "misal");
`ifdef PC_MISALIGN_TRAP_EN
    check("misal_pc", pc_o, TV);
    check("misal_pulse", {31'd0, misalign_o}, 32'd1);
    check("misal_bad", bad_addr_o, 32'h202);
`else
    check("misal_pc", pc_o, 32'h200);
    check("misal_pulse", {31'd0, misalign_o}, 32'd0);
`endif
    tick(0, 0, 0, 0, 0, 0, "misal_after");
    check("misal_after_pulse", {31'd0, misalign_o}, 32'd0);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        assert_reset("rnd_rst");
        release_reset("rnd_rel");
      end
      a1 = $urandom; a2 = $urandom;
      if ($urandom_range(0, 3) != 0) a1[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) a2[1:0] = 2'b00;
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, a1, $urandom_range(0, 3) == 0, a2, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen_unit.md
PC_GEN_UNIT -- requirements
Module: pc_gen_unit

Interface
REQ-001 Parameters SHALL be:
- XLEN, default 32, PC width.
- RESET_VECTOR, default 32'h0000_0000, PC value after reset.
- BOOT_DELAY, default 2, idle cycles after reset release before the first valid PC; range 0..15.
- TRAP_VECTOR, default 32'h0000_0100, misalignment trap target.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_i, in, 1, single clock; all state updates on the rising edge.
- rst_ni, in, 1, asynchronous active-low reset.
- busy_i, in, 1, hold request from a multi-cycle unit.
- stall_i, in, 1, hold request from the hazard unit.
- trap_valid_i, in, 1, trap redirect request.
- trap_target_i, in, XLEN, trap target address.
- redirect_valid_i, in, 1, branch/jump redirect request.
- redirect_target_i, in, XLEN, branch/jump target address.
- pc_o, out, XLEN, current fetch PC.
- pc_valid_o, out, 1, pc_o is fetchable.
- redirect_pending_o, out, 1, a captured redirect is waiting for hold release.
- misalign_o, out, 1, one-cycle misaligned-target pulse.
- bad_addr_o, out, XLEN, last misaligned target.

Function
REQ-003 The FSM SHALL have states BOOT, RUN and HELD.
REQ-004 BOOT SHALL count BOOT_DELAY cycles with pc_valid_o=0, then enter RUN; with BOOT_DELAY=0, RUN SHALL be entered on the first clock edge after reset release.
REQ-005 Trap and redirect inputs arriving in BOOT SHALL be dropped.
REQ-006 In RUN with hold=(busy_i|stall_i)=0, pc_o SHALL update every cycle using this priority: trap input > redirect input > pc_o+4.
REQ-007 Redirect latency SHALL be one cycle: a request on edge N SHALL appear on pc_o after edge N.
REQ-008 pc_o+4 SHALL wrap modulo 2^XLEN, so 32'hFFFF_FFFC is followed by 32'h0000_0000.
REQ-009 hold=1 in RUN SHALL move the FSM to HELD, with pc_o frozen from that edge.
REQ-010 In HELD, a trap or redirect input SHALL be captured into a single pending slot and redirect_pending_o=1 from the next cycle.
REQ-011 Pending slot replacement SHALL follow these rules:
- A trap overwrites any pending entry.
- A redirect overwrites a pending redirect.
- A redirect is discarded if a trap is pending.
REQ-012 On the first cycle with hold=0 in HELD, pc_o SHALL load, in priority order: trap input > pending trap > redirect input > pending redirect > pc_o+4. The pending slot and redirect_pending_o SHALL clear on that edge, and the FSM SHALL return to RUN.
REQ-013 pc_valid_o SHALL be 1 in RUN and HELD.

Reset
REQ-014 rst_ni=0 SHALL asynchronously force the following, including mid-operation, regardless of hold or pending state:
- pc_o=RESET_VECTOR
- pc_valid_o=0
- redirect_pending_o=0
- misalign_o=0
- bad_addr_o=0
- pending slot cleared
- BOOT counter cleared
- FSM=BOOT
REQ-015 Reset release SHALL be honoured on the next rising clock edge.

Configuration
REQ-016 With PC_MISALIGN_TRAP_EN defined, a selected target whose bits [1:0] are nonzero SHALL load TRAP_VECTOR instead of the target. In the same cycle as that load, misalign_o SHALL pulse 1 for one cycle and bad_addr_o SHALL capture the raw target.
REQ-017 Without PC_MISALIGN_TRAP_EN, target bits [1:0] SHALL be forced to 0 and misalign_o and bad_addr_o SHALL be tied to 0. The port list SHALL be identical in both builds.

Structure
REQ-018 A shared package pc_gen_pkg SHALL hold:
- the FSM state enum;
- the pending-kind enum (NONE, REDIR, TRAP);
- INSTR_BYTES=4;
- default RESET_VECTOR and TRAP_VECTOR constants.
REQ-019 The pending slot and its priority/overwrite logic SHALL be a sub-module named pc_redirect_latch.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Reset with BOOT_DELAY=2: pc_valid_o=0 for 2 cycles, then pc_o sequence 0x0, 0x4, 0x8.
- Redirect to 0x200 in RUN: pc_o=0x200 after the next edge, then 0x204.
- Redirect to 0x300 during stall_i=1, then trap to 0x100 before release: redirect_pending_o=1; on release pc_o=0x100.
- pc_o=0xFFFF_FFFC with no hold: next pc_o=0x0.
- rst_ni=0 asserted mid-HELD with a pending redirect: pc_o=RESET_VECTOR and redirect_pending_o=0 immediately, with no clock edge.
- PC_MISALIGN_TRAP_EN build, redirect to 0x202: pc_o=TRAP_VECTOR, misalign_o=1 for one cycle, bad_addr_o=0x202.
- Non-PC_MISALIGN_TRAP_EN build, redirect to 0x202: pc_o=0x200, misalign_o=0.
